// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, underrun fill word and the link state encoding
// used by both the responder and the initiator.
package spi_pkg;
  localparam int SPI_W_DEFAULT = 8;
  localparam logic [SPI_W_DEFAULT-1:0] IDLE_FILL_DEFAULT = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a history flop
// producing single-cycle rise/fall pulses in the clk domain.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              hist;

  // Flops reset to 0 so that a CS_N held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~hist;
  assign fall = ~sync[STAGES-1] & hist;
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples SCK/CS_N/MOSI in the clk domain, shifts MSB-first
// words in and out, and exposes byte-wide tx/rx interfaces to the core side.
module spi_responder
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_W_DEFAULT,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(IDLE_FILL_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              frame_err,
  output spi_state_e        fsm_state
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   mosi_sync;

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, rx_next, load_word;
  logic              tx_pending, skip_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];

  assign rx_next   = {rx_shift[DATA_W-2:0], mosi_sync};
  assign load_word = tx_valid ? tx_data : IDLE_FILL;

  // tx handshake: tx_data is sampled whenever a word load happens with tx_valid high, and
  // tx_ready pulses for one cycle right after; the producer may then present the next word.
  // With tx_valid low the load takes IDLE_FILL and underrun pulses instead. rx_valid has no
  // back-pressure: rx_data is replaced at every completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
      tx_pending <= 1'b0;
      skip_fall  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            skip_fall <= 1'b0;
            // A word left over from a cleanly ended frame is sent as-is.
            if (!tx_pending) begin
              tx_shift   <= load_word;
              tx_ready   <= tx_valid;
              underrun   <= ~tx_valid;
              tx_pending <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (bit_cnt != '0) begin
              frame_err  <= 1'b1;
              tx_pending <= 1'b0;
            end
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt    <= '0;
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                tx_shift   <= load_word;
                tx_ready   <= tx_valid;
                underrun   <= ~tx_valid;
                tx_pending <= 1'b1;
                skip_fall  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            // The fall after a word-boundary load must keep the new MSB on the pin.
            if (sclk_fall) begin
              if (skip_fall) skip_fall <= 1'b0;
              else           tx_shift  <= {tx_shift[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso_oe   = (state == SHIFT);
  assign spi_miso  = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b1;
  assign fsm_state = state;
endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: mode-0 initiator BFM, tx word producer, pulse
// monitors, and one task per scenario with hand-computed expectations.
module tb_spi_responder;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, underrun, frame_err;
  spi_state_e fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_rxv, n_txr, n_und, n_ferr;
  logic [7:0] txq[$];
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  spi_responder dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
    .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // monitors and tx producer, all away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin n_rxv++; rx_q.push_back(rx_data); end
    if (tx_ready) n_txr++;
    if (underrun) n_und++;
    if (frame_err) n_ferr++;
    if (tx_ready && txq.size() > 0) tx_log.push_back(txq.pop_front());
    tx_valid = (txq.size() > 0);
    tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
  end

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  task automatic clear_counts();
    n_rxv = 0; n_txr = 0; n_und = 0; n_ferr = 0;
    rx_q.delete(); tx_log.delete(); exp_q.delete();
  endtask

  // driver tasks: SCK period 80 ns, MOSI changes on the falling side, MISO sampled at the rise
  task automatic cs_low();
    @(negedge clk); spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk); spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits,
                           output logic [7:0] miso_bits, output int oe_hi);
    miso_bits = 8'h00; oe_hi = 0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = w[7-i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      miso_bits = {miso_bits[6:0], spi_miso};
      if (miso_oe) oe_hi++;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({spi_miso, miso_oe} !== 2'b10) begin n_err++; $display("FAIL reset_pins: got miso/oe %b want 10", {spi_miso, miso_oe}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if ({rx_valid, tx_ready, underrun, frame_err} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", {rx_valid, tx_ready, underrun, frame_err}); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // A5 goes out at cs fall; 55 is preloaded at the word boundary and kept for the next frame.
  task automatic test_single();
    logic [7:0] m; int oe;
    clear_counts();
    txq.push_back(8'hA5); txq.push_back(8'h55);
    exp_q.push_back(8'h3C);
    repeat (2) @(negedge clk);
    n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL t1_oe_before: got %b want 0", miso_oe); end
    cs_low();
    n_cmp++; if (fsm_state !== SHIFT) begin n_err++; $display("FAIL t1_state_shift: got %0d want SHIFT", fsm_state); end
    send_bits(8'h3C, 8, m, oe);
    cs_high();
    n_cmp++; if (m !== 8'hA5) begin n_err++; $display("FAIL t1_miso: got %h want a5", m); end
    n_cmp++; if (oe !== 8) begin n_err++; $display("FAIL t1_oe_in_frame: got %0d samples want 8", oe); end
    n_cmp++; if ({spi_miso, miso_oe} !== 2'b10) begin n_err++; $display("FAIL t1_pins_after: got %b want 10", {spi_miso, miso_oe}); end
    n_cmp++; if (n_rxv !== 1) begin n_err++; $display("FAIL t1_rx_count: got %0d want 1", n_rxv); end
    n_cmp++; if (rx_at(0) !== exp_q[0]) begin n_err++; $display("FAIL t1_rx_word: got %h want %h", rx_at(0), exp_q[0]); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL t1_rx_data: got %h want 3c", rx_data); end
    n_cmp++; if (n_txr !== 2) begin n_err++; $display("FAIL t1_tx_ready_count: got %0d want 2", n_txr); end
    n_cmp++; if ({tx_at(0), tx_at(1)} !== 16'hA555) begin n_err++; $display("FAIL t1_tx_order: got %h want a555", {tx_at(0), tx_at(1)}); end
    n_cmp++; if ({n_und, n_ferr} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL t1_no_err: got und %0d ferr %0d want 0 0", n_und, n_ferr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2; int oe;
    clear_counts();
    txq.push_back(8'hAA);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    repeat (2) @(negedge clk);
    cs_low();
    send_bits(8'h12, 8, m1, oe);
    send_bits(8'h34, 8, m2, oe);
    cs_high();
    n_cmp++; if (m1 !== 8'h55) begin n_err++; $display("FAIL t2_miso_w1: got %h want 55", m1); end
    n_cmp++; if (m2 !== 8'hAA) begin n_err++; $display("FAIL t2_miso_w2: got %h want aa", m2); end
    n_cmp++; if (n_rxv !== 2) begin n_err++; $display("FAIL t2_rx_count: got %0d want 2", n_rxv); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rx_at(i) !== exp_q[i]) begin n_err++; $display("FAIL t2_rx_word%0d: got %h want %h", i, rx_at(i), exp_q[i]); end
    end
    n_cmp++; if (n_ferr !== 0) begin n_err++; $display("FAIL t2_frame_err: got %0d want 0", n_ferr); end
    n_cmp++; if ({n_txr, n_und} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL t2_loads: got ready %0d und %0d want 1 1", n_txr, n_und); end
  endtask

  task automatic test_frame_err();
    logic [7:0] m; int oe;
    clear_counts();
    cs_low();
    send_bits(8'hB0, 5, m, oe);
    cs_high();
    n_cmp++; if (n_ferr !== 1) begin n_err++; $display("FAIL t4_frame_err: got %0d want 1", n_ferr); end
    n_cmp++; if (n_rxv !== 0) begin n_err++; $display("FAIL t4_no_rx: got %0d want 0", n_rxv); end
    n_cmp++; if (m[4:0] !== 5'b11111) begin n_err++; $display("FAIL t4_miso_kept_fill: got %b want 11111", m[4:0]); end
    n_cmp++; if ({n_txr, n_und} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL t4_no_load: got ready %0d und %0d want 0 0", n_txr, n_und); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL t4_state_idle: got %0d want IDLE", fsm_state); end
  endtask

  // After the frame error nothing is pending, so cs fall loads again; tx_valid is low.
  task automatic test_underrun();
    logic [7:0] m; int oe;
    clear_counts();
    cs_low();
    n_cmp++; if (n_und !== 1) begin n_err++; $display("FAIL t3_underrun_at_cs: got %0d want 1", n_und); end
    send_bits(8'h81, 8, m, oe);
    cs_high();
    n_cmp++; if (m !== 8'hFF) begin n_err++; $display("FAIL t3_miso_fill: got %h want ff", m); end
    n_cmp++; if (n_rxv !== 1) begin n_err++; $display("FAIL t3_rx_count: got %0d want 1", n_rxv); end
    n_cmp++; if (rx_at(0) !== 8'h81) begin n_err++; $display("FAIL t3_rx_word: got %h want 81", rx_at(0)); end
    n_cmp++; if ({n_txr, n_und} !== {32'd0, 32'd2}) begin n_err++; $display("FAIL t3_loads: got ready %0d und %0d want 0 2", n_txr, n_und); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] m; int oe;
    clear_counts();
    txq.push_back(8'h66);
    repeat (2) @(negedge clk);
    cs_low();
    send_bits(8'h7E, 3, m, oe);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++; if ({spi_miso, miso_oe} !== 2'b10) begin n_err++; $display("FAIL t5_pins_in_reset: got %b want 10", {spi_miso, miso_oe}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL t5_rx_data_cleared: got %h want 00", rx_data); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL t5_state_reset: got %0d want IDLE", fsm_state); end
    @(negedge clk); rst_n = 1'b1;
    clear_counts();
    // CS_N stays low across reset: no frame may start without a fresh fall
    send_bits(8'h00, 5, m, oe);
    n_cmp++; if (oe !== 0) begin n_err++; $display("FAIL t5_no_oe_without_fall: got %0d samples want 0", oe); end
    n_cmp++; if (m[4:0] !== 5'b11111) begin n_err++; $display("FAIL t5_idle_miso: got %b want 11111", m[4:0]); end
    cs_high();
    cs_low();
    send_bits(8'h7E, 8, m, oe);
    cs_high();
    n_cmp++; if (m !== 8'h66) begin n_err++; $display("FAIL t5_miso: got %h want 66", m); end
    n_cmp++; if (n_rxv !== 1) begin n_err++; $display("FAIL t5_rx_count: got %0d want 1", n_rxv); end
    n_cmp++; if (rx_at(0) !== 8'h7E) begin n_err++; $display("FAIL t5_rx_word: got %h want 7e", rx_at(0)); end
    n_cmp++; if ({n_txr, n_und} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL t5_loads: got ready %0d und %0d want 1 1", n_txr, n_und); end
  endtask

  task automatic test_idle_sck();
    logic [7:0] m; int oe;
    clear_counts();
    txq.push_back(8'h11);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      send_bits(8'($urandom_range(0, 255)), 8, m, oe);
      n_cmp++; if (m !== 8'hFF) begin n_err++; $display("FAIL t6_miso_idle%0d: got %h want ff", k, m); end
      n_cmp++; if (oe !== 0) begin n_err++; $display("FAIL t6_oe_idle%0d: got %0d samples want 0", k, oe); end
    end
    repeat (8) @(negedge clk);
    n_cmp++; if ({n_rxv, n_txr} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL t6_no_activity: got rxv %0d ready %0d want 0 0", n_rxv, n_txr); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_underrun();
    test_reset_mid_frame();
    test_idle_sck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
